// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES request arbiter.
//   - arb_state_t : arbiter FSM states
//   - AES_BLK_W   : AES block / key width in bits
//   - DEF_*       : default watchdog and re-arm gap lengths
package aes_arb_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int DEF_TIMEOUT_CYC = 63;
  localparam int DEF_GAP_CYC     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    RUN   = 3'd2,
    RESP  = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_valid : pending request bits, one per requester
//   rr_ptr    : index that has highest priority this round
//   winner    : first set req_valid at or after rr_ptr, wrapping
//   any_valid : at least one request pending
module aes_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  int idx;

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins and
  // later hits are masked by any_valid.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES_top core between NUM_REQ requesters.
// Round-robin selects a pending request, launches it on the core, holds
// core inputs stable until the core reports valid (or the watchdog
// expires), then returns the result tagged with the requester index.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. req_ready is a one-cycle one-hot pulse in GRANT;
// rsp_valid stays high with rsp_id/rsp_data/rsp_err frozen until
// rsp_ready is seen.
//
// Ports:
//   AES_clk, AES_rst_n   : clock, async active-low reset
//   req_valid/req_ready  : per-requester request handshake
//   req_data, req_key    : 128-bit words packed per requester
//   rsp_*                : result channel (rsp_err = watchdog abort)
//   core_*               : to/from the AES_top instance
//   busy                 : FSM not in IDLE
//   state_dbg            : current FSM state
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                         AES_clk,
  input  logic                         AES_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_data,
  input  logic [NUM_REQ*AES_BLK_W-1:0] req_key,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [AES_BLK_W-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         core_en,
  output logic [AES_BLK_W-1:0]         core_data_in,
  output logic [AES_BLK_W-1:0]         core_key_in,
  input  logic [AES_BLK_W-1:0]         core_data_out,
  input  logic                         core_data_out_valid,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);

  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, winner, id_q, ptr_nxt;
  logic                 any_valid;
  logic [AES_BLK_W-1:0] data_q, key_q, rsp_data_q;
  logic                 rsp_err_q;
  logic [WD_W-1:0]      wd_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 wd_expired, gap_done;

  aes_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // wd_cnt is 0 in the first RUN cycle, so expiry on TIMEOUT_CYC-1 keeps
  // core_en high for at most TIMEOUT_CYC cycles.
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign gap_done   = (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign ptr_nxt    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE:  if (|req_valid) state_nxt = GRANT;
      GRANT: begin
        if (any_valid) begin
          req_ready[winner] = 1'b1;
          state_nxt         = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      // A core valid in the expiry cycle takes priority (success).
      RUN:   if (core_data_out_valid || wd_expired) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = GAP;
      GAP:   if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      rr_ptr     <= '0;
      id_q       <= '0;
      data_q     <= '0;
      key_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wd_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        GRANT: begin
          if (any_valid) begin
            data_q <= req_data[int'(winner)*AES_BLK_W +: AES_BLK_W];
            key_q  <= req_key[int'(winner)*AES_BLK_W +: AES_BLK_W];
            id_q   <= winner;
            rr_ptr <= ptr_nxt;
            wd_cnt <= '0;
          end
        end
        RUN: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (core_data_out_valid) begin
            rsp_data_q <= core_data_out;
            rsp_err_q  <= 1'b0;
          end else if (wd_expired) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP:    gap_cnt <= '0;
        GAP:     gap_cnt <= gap_cnt + GAP_W'(1);
        default: ;
      endcase
    end
  end

  // Outputs decode directly from state so a reset clears them at once.
  assign core_en      = (state == RUN);
  assign core_data_in = data_q;
  assign core_key_in  = key_q;
  assign rsp_valid    = (state == RESP);
  assign rsp_id       = id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_aes_req_arbiter.sv
module tb_aes_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 63;
  localparam int GC = 2;
  localparam int EW = 1 + 8 + 128;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_data  = '0;
  logic [N*128-1:0] req_key   = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IW-1:0]    rsp_id;
  logic [127:0]     rsp_data;
  logic             rsp_err;
  logic             core_en;
  logic [127:0]     core_data_in, core_key_in;
  logic [127:0]     core_data_out = '0;
  logic             core_data_out_valid = 1'b0;
  logic             busy;
  logic [2:0]       state_dbg;

  aes_req_arbiter #(
    .NUM_REQ (N), .ID_W (IW), .TIMEOUT_CYC (TO), .GAP_CYC (GC)
  ) dut (
    .AES_clk             (clk),
    .AES_rst_n           (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_data            (req_data),
    .req_key             (req_key),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_id              (rsp_id),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .core_en             (core_en),
    .core_data_in        (core_data_in),
    .core_key_in         (core_key_in),
    .core_data_out       (core_data_out),
    .core_data_out_valid (core_data_out_valid),
    .busy                (busy),
    .state_dbg           (state_dbg)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bench controls ----------------
  int pend[N];
  bit rand_data = 1'b0;
  bit rsp_rand  = 1'b0;
  bit spur      = 1'b0;
  int core_lat  = 10;

  // ---------------- reference model state ----------------
  logic [EW-1:0] exp_q[$];
  int            gq[$];
  int            m_ptr = 0;
  int            ready_cnt[N];
  logic [127:0]  cur_data = '0, cur_key = '0;
  int            en_len = 0, low_len = 0, last_en_len = 0;
  bit            prev_en = 1'b0, had_op = 1'b0;

  // Round-robin rule: first pending index at or after ptr, wrapping.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // ---------------- requester driver ----------------
  always begin : drv
    logic [N-1:0] took;
    @(negedge clk);
    took = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (took[i] || !req_valid[i]) begin
        if (took[i]) pend[i]--;
        if (pend[i] > 0 && rand_data) begin
          req_data[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
          req_key[i*128 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      req_valid[i] = (pend[i] > 0);
    end
    if (rsp_rand) rsp_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- core model: result = data ^ key after core_lat cycles ----------------
  int en_cnt = 0;
  always @(negedge clk) begin
    if (core_en) begin
      en_cnt++;
      core_data_out_valid = (core_lat != 0) && (en_cnt == core_lat);
    end else begin
      en_cnt = 0;
      core_data_out_valid = spur && ($urandom_range(0, 3) == 0);
    end
    core_data_out = (core_data_out_valid && core_en) ? (core_data_in ^ core_key_in)
                                                     : {$urandom, $urandom, $urandom, $urandom};
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    int            w;
    logic          er;
    logic [EW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      gq.delete();
      m_ptr   = 0;
      prev_en = 1'b0;
      had_op  = 1'b0;
      en_len  = 0;
      low_len = 0;
    end else begin
      if (req_ready != '0) begin
        w = pick(req_valid, m_ptr);
        check("grant_onehot", req_ready, (w < 0) ? 0 : (1 << w));
        for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
        if (w >= 0) begin
          cur_data = req_data[w*128 +: 128];
          cur_key  = req_key[w*128 +: 128];
          er = (core_lat == 0) || (core_lat > TO);
          exp_q.push_back({er, 8'(w), er ? 128'h0 : (cur_data ^ cur_key)});
          gq.push_back(w);
          m_ptr = (w + 1) % N;
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q[0];
          check("rsp_id", rsp_id, e[135:128]);
          check("rsp_data", rsp_data, e[127:0]);
          check("rsp_err", rsp_err, e[136]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (core_en) begin
        if (!prev_en) begin
          // RESP + GAP + IDLE + GRANT all keep core_en low.
          if (had_op) check("core_gap", low_len >= GC + 3, 1);
          en_len = 0;
        end
        en_len++;
        check("core_data_in", core_data_in, cur_data);
        check("core_key_in", core_key_in, cur_key);
      end else begin
        if (prev_en) begin
          last_en_len = en_len;
          had_op      = 1'b1;
          low_len     = 0;
        end
        low_len++;
      end
      prev_en = core_en;
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < N; i++) if (pend[i] != 0) return 1'b0;
    return !busy && (exp_q.size() == 0) && (req_valid == '0) && !rsp_valid;
  endfunction

  task automatic drain(input int budget);
    int k = 0;
    while (k < budget && !all_idle()) begin
      cyc(1);
      k++;
    end
    if (k >= budget) check("drain_timeout", 1, 0);
    cyc(1);
  endtask

  task automatic wait_rsp(input int budget);
    int k = 0;
    @(negedge clk);
    while (k < budget && !rsp_valid) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (k >= budget) check("rsp_wait_timeout", 1, 0);
  endtask

  task automatic wait_en(input int budget);
    int k = 0;
    while (k < budget && !core_en) begin
      cyc(1);
      k++;
    end
    if (k >= budget) check("en_wait_timeout", 1, 0);
  endtask

  task automatic clr_ready_cnt();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [127:0] exp_d;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      ready_cnt[i] = 0;
    end
    rst_n = 1'b0;
    cyc(3);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_en", core_en, 0);
    check("rst_busy", busy, 0);
    check("rst_core_data", core_data_in, 0);
    check("rst_core_key", core_key_in, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: single request from requester 1
    req_data[1*128 +: 128] = 128'h000000a1_00000000_00000000_00000000;
    req_key[1*128 +: 128]  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    rsp_ready = 1'b1;
    core_lat  = 10;
    clr_ready_cnt();
    pend[1] = 1;
    wait_rsp(100);
    check("t1_id", rsp_id, 1);
    check("t1_data", rsp_data, 128'haa2bdbe1_bff6a5e8_caa9ba3e_bc1e2acc);
    check("t1_err", rsp_err, 0);
    check("t1_en_len", last_en_len, 10);
    // follow-on request so the re-arm gap gets measured
    req_data[0 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    req_key[0 +: 128]  = {$urandom, $urandom, $urandom, $urandom};
    pend[0] = 1;
    drain(300);
    check("t1_pulses", ready_cnt[1], 1);
    check("t1_pulses_other", ready_cnt[2] + ready_cnt[3], 0);

    // 2: all four requesting continuously from reset
    rst_n = 1'b0;
    cyc(2);
    rand_data = 1'b1;
    core_lat  = $urandom_range(3, 15);
    for (int i = 0; i < N; i++) pend[i] = 2;
    cyc(2);
    rst_n = 1'b1;
    drain(3000);
    check("t2_count", gq.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t2_order%0d", k), (k < gq.size()) ? gq[k] : -1, k % N);

    // 3: response backpressure
    rsp_ready = 1'b0;
    pend[2] = 1;
    wait_rsp(200);
    pend[0] = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      exp_d = (exp_q.size() > 0) ? exp_q[0][127:0] : '1;
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_d);
      check("bp_core_en", core_en, 0);
      check("bp_no_grant", req_ready, 0);
    end
    cyc(1);
    rsp_ready = 1'b1;
    drain(300);

    // 4: watchdog timeout, then a normal operation
    core_lat = 0;
    pend[1] = 1;
    wait_rsp(300);
    check("t4_err", rsp_err, 1);
    check("t4_data", rsp_data, 0);
    check("t4_en_len", last_en_len, TO);
    drain(300);
    core_lat = 7;
    pend[3] = 1;
    wait_rsp(200);
    check("t4_next_err", rsp_err, 0);
    check("t4_next_en_len", last_en_len, 7);
    drain(300);

    // 5: reset in the middle of RUN
    core_lat = 40;
    pend[3] = 1;
    wait_en(100);
    cyc(3);
    #1;
    rst_n = 1'b0;
    pend[2] = 1;
    #1;
    check("t5_core_en", core_en, 0);
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_req_ready", req_ready, 0);
    check("t5_core_data", core_data_in, 0);
    check("t5_core_key", core_key_in, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_rsp_err", rsp_err, 0);
    cyc(2);
    rst_n = 1'b1;
    wait_rsp(200);
    check("t5_first_grant", (gq.size() > 0) ? gq[0] : -1, 2);
    check("t5_rsp_id", rsp_id, 2);
    drain(300);

    // 6: core valid in the same cycle as the watchdog limit
    core_lat = TO;
    pend[0] = 1;
    wait_rsp(300);
    check("t6_err", rsp_err, 0);
    check("t6_data", rsp_data, req_data[0 +: 128] ^ req_key[0 +: 128]);
    check("t6_en_len", last_en_len, TO);
    drain(300);

    // random traffic: mixed latencies, random rsp_ready, spurious core valids
    rsp_rand = 1'b1;
    spur     = 1'b1;
    for (int b = 0; b < 6; b++) begin
      core_lat = ($urandom_range(0, 4) == 0) ? TO : $urandom_range(1, 12);
      for (int i = 0; i < N; i++) pend[i] = $urandom_range(0, 3);
      drain(6000);
    end
    rsp_rand  = 1'b0;
    spur      = 1'b0;
    rsp_ready = 1'b1;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
Shares one AES_top encryption core between NUM_REQ independent requesters.
- Round-robin arbitration picks one pending request and launches it on the core.
- Holds core_en, data and key stable until the core asserts valid, then returns the result with the requester's ID.
- A watchdog aborts a hung operation.
- Sits between the system request sources and the AES_top instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index
TIMEOUT_CYC, 63, max cycles core_en may stay high without core_data_out_valid
GAP_CYC, 2, minimum cycles core_en is held low between operations (core re-arm)

Ports:
AES_clk  in  1  clock, rising edge
AES_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept pulse; transfer when valid&ready
req_data  in  NUM_REQ*128  plaintext; requester i on bits [128i+127:128i]
req_key  in  NUM_REQ*128  key, same packing
rsp_valid  out  1  result available
rsp_ready  in  1  downstream accepts result
rsp_id  out  ID_W  requester index of the result
rsp_data  out  128  ciphertext; all-zero when rsp_err=1
rsp_err  out  1  operation aborted by watchdog
core_en  out  1  to AES_top AES_en
core_data_in  out  128  to AES_top AES_data_in
core_key_in  out  128  to AES_top AES_key_in
core_data_out  in  128  from AES_top AES_data_out
core_data_out_valid  in  1  from AES_top AES_data_out_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, AES_rst_n=0): state=IDLE; rr_ptr=0; all outputs 0 (req_ready, rsp_*, core_en, core_data_in, core_key_in, busy). Reset mid-operation abandons the operation, with no response. core_en drops immediately.
- FSM: IDLE, GRANT, RUN, RESP, GAP.
- IDLE: if any req_valid, go to GRANT next cycle.
- GRANT (1 cycle):
  - Winner = first asserted req_valid at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 for exactly this cycle.
  - Register data, key and winner ID.
  - rr_ptr <= winner+1 mod NUM_REQ.
  - If req_valid dropped so that none is set, return to IDLE with no ready.
- RUN:
  - core_en=1, with core_data_in/core_key_in driven from the registers, stable for the whole state.
  - wd counter starts at 0 and increments each cycle.
  - On core_data_out_valid=1: capture core_data_out, set rsp_err=0, go to RESP.
  - If wd reaches TIMEOUT_CYC with no valid: rsp_data=0, rsp_err=1, go to RESP.
  - Valid arriving in the same cycle as the timeout counts as success.
- RESP:
  - core_en=0; rsp_valid=1 with rsp_id/rsp_data/rsp_err stable until rsp_ready.
  - On rsp_valid&rsp_ready go to GAP.
  - rsp_ready high on the first RESP cycle gives a 1-cycle RESP.
- GAP: core_en=0 for GAP_CYC cycles, counted by gap counter, then IDLE.
- Latency: req accepted (GRANT) to core_en high = 1 cycle. core valid to rsp_valid = 1 cycle.
- core_data_out_valid outside RUN is ignored.
- req_valid changes outside GRANT have no effect. Requesters must hold data and key stable while valid and not ready.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 operations.
- Only one operation is in flight at any time; there is no queuing.

Decomposition:
- aes_arb_pkg holds:
  - state enum (IDLE/GRANT/RUN/RESP/GAP)
  - AES_BLK_W=128 constant
  - default TIMEOUT_CYC/GAP_CYC constants
- One natural sub-module, aes_rr_pick: combinational round-robin picker with inputs req_valid and rr_ptr, outputs winner ID and any_valid.
- Counters and FSM stay in the top.

Test Plan:
Bench drives a core model: latency 10 cycles after core_en rises, result = data XOR key.
1. Single request: req 1 with data 000000a1_00000000_00000000_00000000, key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, rsp_ready=1 -> req_ready[1] pulses once; core_en high 10 cycles; rsp_id=1, rsp_data=aa2bdbe1_bff6a5e8_caa9ba3e_bc1e2acc, rsp_err=0; core_en low at least GAP_CYC cycles afterwards.
2. All four requesting continuously from reset -> grant order 0,1,2,3,0. No requester served twice before the others.
3. Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid/rsp_data held stable; no new grant until the handshake; core_en stays 0.
4. Timeout: core model never asserts valid -> after TIMEOUT_CYC cycles rsp_err=1, rsp_data=0; next request proceeds normally.
5. Reset asserted mid-RUN -> all outputs 0 asynchronously (before the next edge), no rsp_valid. After release, a pending req 2 is granted first from rr_ptr=0 and completes.
6. Valid and timeout in the same cycle, using a model with latency exactly TIMEOUT_CYC -> rsp_err=0 with the correct data.
